// File: rtl/ppu_video_memory_pkg.sv
// Shared constants and types for the PPU video-bus memory responder.
// Address map, memory sizes and region encoding used by decode and storage.
package ppu_video_memory_pkg;

  localparam logic [13:0] CHR_BASE      = 14'h0000;
  localparam logic [13:0] NT_BASE       = 14'h2000;
  localparam logic [13:0] NT_MIRROR_END = 14'h3EFF;
  localparam logic [13:0] PALETTE_BASE  = NT_MIRROR_END + 14'h0001;

  localparam int CHR_BYTES  = 8192;
  localparam int VRAM_BYTES = 2048;
  localparam int CHR_AW     = $clog2(CHR_BYTES);
  localparam int VRAM_AW    = $clog2(VRAM_BYTES);

  typedef enum logic [1:0] {
    REGION_CHR,
    REGION_NT,
    REGION_PALETTE
  } region_e;

endpackage

// File: rtl/ppu_video_address_decode.sv
// Combinational video address decode: region plus physical CHR/VRAM index.
// Zero latency, no state; shared by the PPU and loader paths.
module ppu_video_address_decode
  import ppu_video_memory_pkg::*;
(
  input  logic [13:0]       address,
  input  logic              mirror_vertical,
  output region_e           region,
  output logic [CHR_AW-1:0] index
);

  logic [CHR_AW-1:0] chr_off;
  logic              nt_bank;

  always_comb begin
    chr_off = address[CHR_AW-1:0] - CHR_BASE[CHR_AW-1:0];
    // Palette reads alias a-0x1000, which only flips bit 12, so bits 11:0 index the same way.
    nt_bank = mirror_vertical ? address[10] : address[11];
    region  = REGION_NT;
    index   = {{(CHR_AW-VRAM_AW){1'b0}}, nt_bank, address[9:0]};
    if (address < NT_BASE) begin
      region = REGION_CHR;
      index  = chr_off;
    end else if (address >= PALETTE_BASE) begin
      region = REGION_PALETTE;
    end
  end

endmodule

// File: rtl/ppu_video_memory.sv
// PPU video-bus responder: 8 KB CHR + 2 KB mirrored VRAM, zero-wait reads, falling-edge writes.
// Loader port is ready whenever the PPU is not writing; sticky monitors for debug.
module ppu_video_memory
  import ppu_video_memory_pkg::*;
#(
  parameter bit CHR_IS_RAM        = 1'b0,
  parameter int WRITE_COUNT_WIDTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_video_rd_n,
  input  logic                         i_video_we_n,
  input  logic [13:0]                  i_video_address,
  input  logic [7:0]                   i_video_data,
  output logic [7:0]                   o_video_data,
  input  logic                         i_mirror_vertical,
  input  logic                         i_load_valid,
  output logic                         o_load_ready,
  input  logic [13:0]                  i_load_address,
  input  logic [7:0]                   i_load_data,
  output logic [WRITE_COUNT_WIDTH-1:0] o_write_count,
  output logic [13:0]                  o_last_write_address,
  output logic                         o_bus_error
);

  localparam logic [WRITE_COUNT_WIDTH-1:0] COUNT_ONE = {{(WRITE_COUNT_WIDTH-1){1'b0}}, 1'b1};

  region_e           vid_region;
  region_e           load_region;
  logic [CHR_AW-1:0] vid_index;
  logic [CHR_AW-1:0] load_index;

  ppu_video_address_decode u_vid_decode (
    .address         (i_video_address),
    .mirror_vertical (i_mirror_vertical),
    .region          (vid_region),
    .index           (vid_index)
  );

  ppu_video_address_decode u_load_decode (
    .address         (i_load_address),
    .mirror_vertical (i_mirror_vertical),
    .region          (load_region),
    .index           (load_index)
  );

  logic [7:0] chr_mem  [CHR_BYTES];
  logic [7:0] vram_mem [VRAM_BYTES];

  logic [7:0] rd_byte;

  always_comb begin
    rd_byte = vram_mem[vid_index[VRAM_AW-1:0]];
    if (vid_region == REGION_CHR) begin
      rd_byte = chr_mem[vid_index];
    end
  end

  assign o_video_data = i_video_rd_n ? 8'h00 : rd_byte;
  assign o_load_ready = !i_reset && i_video_we_n;

  logic              video_strobe;
  logic              video_commit;
  logic              load_commit;
  logic              wr_en;
  region_e           wr_region;
  logic [CHR_AW-1:0] wr_index;
  logic [7:0]        wr_data;

  always_comb begin
    video_strobe = !i_video_we_n;
    video_commit = video_strobe &&
                   ((vid_region == REGION_NT) || ((vid_region == REGION_CHR) && CHR_IS_RAM));
    load_commit  = i_load_valid && o_load_ready && (load_region != REGION_PALETTE);
    wr_en        = !i_reset && (video_commit || load_commit);
    // The loader only gets the port when the PPU is not strobing a write.
    wr_region    = video_strobe ? vid_region : load_region;
    wr_index     = video_strobe ? vid_index : load_index;
    wr_data      = video_strobe ? i_video_data : i_load_data;
  end

  always_ff @(negedge i_clk) begin
    if (wr_en && (wr_region == REGION_CHR)) begin
      chr_mem[wr_index] <= wr_data;
    end
    if (wr_en && (wr_region == REGION_NT)) begin
      vram_mem[wr_index[VRAM_AW-1:0]] <= wr_data;
    end
  end

  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      o_write_count        <= '0;
      o_last_write_address <= '0;
      o_bus_error          <= 1'b0;
    end else begin
      if (video_commit && (o_write_count != '1)) begin
        o_write_count <= o_write_count + COUNT_ONE;
      end
      if (video_strobe) begin
        o_last_write_address <= i_video_address;
      end
      if (!i_video_rd_n && video_strobe) begin
        o_bus_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ppu_video_memory.sv
// Bench for ppu_video_memory: directed vector table, hand sequences, and random traffic
// checked against an address-map model; runs a CHR-ROM and a CHR-RAM instance side by side.
module tb_ppu_video_memory;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rd_n, we_n, mv, lv;
  logic [13:0] vaddr, laddr;
  logic [7:0]  vdata, ldata;

  logic [7:0]  rom_rd, ram_rd;
  logic        rom_rdy, ram_rdy;
  logic [15:0] rom_cnt, ram_cnt;
  logic [13:0] rom_last, ram_last;
  logic        rom_err, ram_err;

  ppu_video_memory #(.CHR_IS_RAM(1'b0), .WRITE_COUNT_WIDTH(16)) dut_rom (
    .i_clk(clk), .i_reset(reset), .i_video_rd_n(rd_n), .i_video_we_n(we_n),
    .i_video_address(vaddr), .i_video_data(vdata), .o_video_data(rom_rd),
    .i_mirror_vertical(mv), .i_load_valid(lv), .o_load_ready(rom_rdy),
    .i_load_address(laddr), .i_load_data(ldata), .o_write_count(rom_cnt),
    .o_last_write_address(rom_last), .o_bus_error(rom_err)
  );

  ppu_video_memory #(.CHR_IS_RAM(1'b1), .WRITE_COUNT_WIDTH(16)) dut_ram (
    .i_clk(clk), .i_reset(reset), .i_video_rd_n(rd_n), .i_video_we_n(we_n),
    .i_video_address(vaddr), .i_video_data(vdata), .o_video_data(ram_rd),
    .i_mirror_vertical(mv), .i_load_valid(lv), .o_load_ready(ram_rdy),
    .i_load_address(laddr), .i_load_data(ldata), .o_write_count(ram_cnt),
    .o_last_write_address(ram_last), .o_bus_error(ram_err)
  );

  typedef struct {
    logic        rst, rd_n, we_n;
    logic [13:0] addr;
    logic [7:0]  wdata;
    logic        mv, lv;
    logic [13:0] laddr;
    logic [7:0]  ldata;
    logic        chk_rd;
    logic [7:0]  exp_rd;
    logic        exp_rdy;
    logic [15:0] exp_cnt;
    logic [13:0] exp_last;
    logic        exp_err;
  } vec_t;

  // Reference model: index 0 = CHR-ROM instance, 1 = CHR-RAM instance.
  logic [7:0] chr_m [2][8192];
  logic [7:0] vram_m [2048];
  int         cnt_m [2];
  int         last_m;
  bit         err_m;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  function automatic vec_t v(logic r, logic rdn, logic wen, logic [13:0] a, logic [7:0] wd,
                             logic m, logic l, logic [13:0] la, logic [7:0] ld,
                             logic cr, logic [7:0] er, logic ey, logic [15:0] ec,
                             logic [13:0] el, logic ee);
    vec_t t;
    t.rst = r; t.rd_n = rdn; t.we_n = wen; t.addr = a; t.wdata = wd; t.mv = m;
    t.lv = l; t.laddr = la; t.ldata = ld; t.chk_rd = cr; t.exp_rd = er; t.exp_rdy = ey;
    t.exp_cnt = ec; t.exp_last = el; t.exp_err = ee;
    return t;
  endfunction

  function automatic int nt_idx(int a, bit vert);
    int bank;
    bank = vert ? (a / 1024) % 2 : (a / 2048) % 2;
    return bank * 1024 + (a % 1024);
  endfunction

  function automatic int exp_read(int d, bit rdn, int a, bit vert);
    if (rdn) return 0;
    if (a < 'h2000) return int'(chr_m[d][a]);
    if (a >= 'h3F00) return int'(vram_m[nt_idx(a - 'h1000, vert)]);
    return int'(vram_m[nt_idx(a, vert)]);
  endfunction

  task automatic model_update(input vec_t t);
    int a, la;
    a  = int'(t.addr);
    la = int'(t.laddr);
    if (t.rst) begin
      cnt_m[0] = 0; cnt_m[1] = 0; last_m = 0; err_m = 0;
    end else begin
      if (!t.rd_n && !t.we_n) err_m = 1;
      if (!t.we_n) begin
        last_m = a;
        if (a < 'h2000) begin
          chr_m[1][a] = t.wdata;
          if (cnt_m[1] < 65535) cnt_m[1]++;
        end else if (a < 'h3F00) begin
          vram_m[nt_idx(a, t.mv)] = t.wdata;
          for (int d = 0; d < 2; d++) if (cnt_m[d] < 65535) cnt_m[d]++;
        end
      end else if (t.lv) begin
        if (la < 'h2000) begin
          chr_m[0][la] = t.ldata;
          chr_m[1][la] = t.ldata;
        end else if (la < 'h3F00) begin
          vram_m[nt_idx(la, t.mv)] = t.ldata;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, step_no, act, exp);
    end
  endtask

  // One bus cycle: drive after the rising edge, check combinational outputs before the
  // falling (commit) edge, then check the registered monitors just after it.
  task automatic step(input vec_t t, input bit use_model);
    @(posedge clk);
    #1;
    step_no++;
    reset = t.rst; rd_n = t.rd_n; we_n = t.we_n; vaddr = t.addr; vdata = t.wdata;
    mv = t.mv; lv = t.lv; laddr = t.laddr; ldata = t.ldata;
    #2;
    if (use_model) begin
      chk("rd_rom", 32'(rom_rd), exp_read(0, t.rd_n, int'(t.addr), t.mv));
      chk("rd_ram", 32'(ram_rd), exp_read(1, t.rd_n, int'(t.addr), t.mv));
      chk("rdy_rom", 32'(rom_rdy), 32'(!t.rst && t.we_n));
      chk("rdy_ram", 32'(ram_rdy), 32'(!t.rst && t.we_n));
    end else begin
      if (t.chk_rd) chk("tbl_rd", 32'(rom_rd), 32'(t.exp_rd));
      chk("tbl_rdy", 32'(rom_rdy), 32'(t.exp_rdy));
    end
    @(negedge clk);
    model_update(t);
    #1;
    if (use_model) begin
      chk("cnt_rom", 32'(rom_cnt), cnt_m[0]);
      chk("last_rom", 32'(rom_last), last_m);
      chk("err_rom", 32'(rom_err), 32'(err_m));
    end else begin
      chk("tbl_cnt", 32'(rom_cnt), 32'(t.exp_cnt));
      chk("tbl_last", 32'(rom_last), 32'(t.exp_last));
      chk("tbl_err", 32'(rom_err), 32'(t.exp_err));
    end
    chk("cnt_ram", 32'(ram_cnt), cnt_m[1]);
    chk("last_ram", 32'(ram_last), last_m);
    chk("err_ram", 32'(ram_err), 32'(err_m));
  endtask

  vec_t tbl[$];
  vec_t t;

  initial begin
    reset = 1'b1; rd_n = 1'b1; we_n = 1'b1; vaddr = '0; vdata = '0;
    mv = 1'b0; lv = 1'b0; laddr = '0; ldata = '0;
    cnt_m[0] = 0; cnt_m[1] = 0; last_m = 0; err_m = 0;

    //                rst rd we addr      wd    mv lv laddr     ld    crd erd   rdy cnt last      err
    tbl.push_back(v(1, 1, 1, 14'h0000, 8'h00, 0, 0, 14'h0000, 8'h00, 1, 8'h00, 0, 0, 14'h0000, 0));
    tbl.push_back(v(0, 1, 1, 14'h0000, 8'h00, 0, 1, 14'h0010, 8'hA5, 1, 8'h00, 1, 0, 14'h0000, 0));
    tbl.push_back(v(0, 0, 1, 14'h0010, 8'h00, 0, 0, 14'h0000, 8'h00, 1, 8'hA5, 1, 0, 14'h0000, 0));
    tbl.push_back(v(0, 1, 0, 14'h0010, 8'h11, 0, 0, 14'h0000, 8'h00, 0, 8'h00, 0, 0, 14'h0010, 0));
    tbl.push_back(v(0, 0, 1, 14'h0010, 8'h00, 0, 0, 14'h0000, 8'h00, 1, 8'hA5, 1, 0, 14'h0010, 0));
    tbl.push_back(v(0, 1, 1, 14'h0000, 8'h00, 1, 1, 14'h2405, 8'h00, 1, 8'h00, 1, 0, 14'h0010, 0));
    tbl.push_back(v(0, 1, 0, 14'h2005, 8'h42, 1, 0, 14'h0000, 8'h00, 0, 8'h00, 0, 1, 14'h2005, 0));
    tbl.push_back(v(0, 0, 1, 14'h2805, 8'h00, 1, 0, 14'h0000, 8'h00, 1, 8'h42, 1, 1, 14'h2005, 0));
    tbl.push_back(v(0, 0, 1, 14'h2405, 8'h00, 1, 0, 14'h0000, 8'h00, 1, 8'h00, 1, 1, 14'h2005, 0));
    tbl.push_back(v(0, 0, 1, 14'h2405, 8'h00, 0, 0, 14'h0000, 8'h00, 1, 8'h42, 1, 1, 14'h2005, 0));
    tbl.push_back(v(0, 0, 1, 14'h3005, 8'h00, 0, 0, 14'h0000, 8'h00, 1, 8'h42, 1, 1, 14'h2005, 0));
    tbl.push_back(v(0, 1, 1, 14'h0000, 8'h00, 0, 1, 14'h2301, 8'h5C, 1, 8'h00, 1, 1, 14'h2005, 0));
    tbl.push_back(v(0, 1, 0, 14'h3F01, 8'hEE, 0, 0, 14'h0000, 8'h00, 0, 8'h00, 0, 1, 14'h3F01, 0));
    tbl.push_back(v(0, 0, 1, 14'h2301, 8'h00, 0, 0, 14'h0000, 8'h00, 1, 8'h5C, 1, 1, 14'h3F01, 0));
    tbl.push_back(v(0, 1, 0, 14'h2006, 8'h77, 0, 1, 14'h2010, 8'h99, 0, 8'h00, 0, 2, 14'h2006, 0));
    tbl.push_back(v(0, 1, 1, 14'h0000, 8'h00, 0, 1, 14'h2010, 8'h99, 1, 8'h00, 1, 2, 14'h2006, 0));
    tbl.push_back(v(0, 0, 1, 14'h2006, 8'h00, 0, 0, 14'h0000, 8'h00, 1, 8'h77, 1, 2, 14'h2006, 0));
    tbl.push_back(v(0, 0, 1, 14'h2010, 8'h00, 0, 0, 14'h0000, 8'h00, 1, 8'h99, 1, 2, 14'h2006, 0));
    tbl.push_back(v(0, 0, 0, 14'h2006, 8'h33, 0, 0, 14'h0000, 8'h00, 1, 8'h77, 0, 3, 14'h2006, 1));
    tbl.push_back(v(0, 0, 1, 14'h2006, 8'h00, 0, 0, 14'h0000, 8'h00, 1, 8'h33, 1, 3, 14'h2006, 1));

    foreach (tbl[i]) step(tbl[i], 1'b0);

    // Sticky bus error across idle cycles, then cleared by reset.
    for (int i = 0; i < 100; i++)
      step(v(0, 1, 1, 14'h0000, 8'h00, 0, 0, 14'h0000, 8'h00, 1, 8'h00, 1, 3, 14'h2006, 1), 1'b0);
    step(v(1, 1, 1, 14'h0000, 8'h00, 0, 0, 14'h0000, 8'h00, 1, 8'h00, 0, 0, 14'h0000, 0), 1'b0);

    // Reset blocks a loader commit on the same edge.
    step(v(1, 1, 1, 14'h0000, 8'h00, 0, 1, 14'h2010, 8'hDE, 1, 8'h00, 0, 0, 14'h0000, 0), 1'b0);
    step(v(0, 0, 1, 14'h2010, 8'h00, 0, 0, 14'h0000, 8'h00, 1, 8'h99, 1, 0, 14'h0000, 0), 1'b0);

    // Fill both memories through the loader so the model knows every byte.
    for (int a = 0; a < 8192; a++)
      step(v(0, 1, 1, 14'h0000, 8'h00, 0, 1, 14'(a), 8'($urandom), 0, 8'h00, 0, 0, 14'h0, 0), 1'b1);
    for (int i = 0; i < 2048; i++)
      step(v(0, 1, 1, 14'h0000, 8'h00, 1, 1, 14'(14'h2000 + i), 8'($urandom), 0, 8'h00, 0, 0, 14'h0, 0), 1'b1);

    for (int i = 0; i < 3000; i++) begin
      t = v(0, 1, 1, 14'h0, 8'h0, 0, 0, 14'h0, 8'h0, 0, 8'h0, 0, 0, 14'h0, 0);
      t.rst   = ($urandom_range(0, 63) == 0);
      t.rd_n  = 1'($urandom_range(0, 1));
      t.we_n  = ($urandom_range(0, 2) != 0);
      t.addr  = 14'($urandom_range(0, 16383));
      t.wdata = 8'($urandom);
      t.mv    = 1'($urandom_range(0, 1));
      t.lv    = 1'($urandom_range(0, 1));
      t.laddr = 14'($urandom_range(0, 16383));
      t.ldata = 8'($urandom);
      step(t, 1'b1);
    end

    // Counter saturation: 65540 committed nametable writes from a clean reset.
    step(v(1, 1, 1, 14'h0000, 8'h00, 0, 0, 14'h0000, 8'h00, 0, 8'h00, 0, 0, 14'h0, 0), 1'b1);
    for (int i = 0; i < 65540; i++) begin
      t = v(0, 1, 0, 14'h2000, 8'h00, 0, 0, 14'h0, 8'h0, 0, 8'h0, 0, 0, 14'h0, 0);
      t.addr  = 14'($urandom_range(14'h2000, 14'h3EFF));
      t.wdata = 8'($urandom);
      t.mv    = 1'($urandom_range(0, 1));
      t.rd_n  = ($urandom_range(0, 7) != 0);
      step(t, 1'b1);
    end
    chk("sat_rom", 32'(rom_cnt), 32'hFFFF);
    chk("sat_ram", 32'(ram_cnt), 32'hFFFF);
    step(v(0, 1, 0, 14'h0123, 8'h5A, 0, 0, 14'h0000, 8'h00, 0, 8'h00, 0, 0, 14'h0, 0), 1'b1);
    chk("sat_hold_ram", 32'(ram_cnt), 32'hFFFF);

    // Reset in the middle of a loader transfer: no byte lands, counters return to zero.
    t = v(1, 1, 1, 14'h0000, 8'h00, 0, 1, 14'h0777, 8'h00, 0, 8'h00, 0, 0, 14'h0, 0);
    t.ldata = ~chr_m[0][14'h0777];
    step(t, 1'b1);
    chk("rst_cnt_rom", 32'(rom_cnt), 32'h0);
    chk("rst_cnt_ram", 32'(ram_cnt), 32'h0);
    step(v(0, 0, 1, 14'h0777, 8'h00, 0, 0, 14'h0000, 8'h00, 0, 8'h00, 0, 0, 14'h0, 0), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_video_memory.md
Name: ppu_video_memory

Overview:
- Responder on the PPU video bus: 8 KB pattern memory (CHR) plus 2 KB nametable VRAM behind the PPU's 14-bit video address bus.
- Decodes the address, applies nametable mirroring, serves reads and commits writes issued by the PPU.
- Also provides a valid/ready loader port, so the testbench or cartridge loader can fill CHR/VRAM, and sticky bus monitors for debug.

Parameters:
- CHR_IS_RAM, 0, 1 = video-bus writes to 0x0000-0x1FFF are committed; 0 = ignored (CHR ROM). Loader writes are always committed.
- WRITE_COUNT_WIDTH, 16, width of the saturating video-write counter.

Ports:
- i_clk  input  1  clock; all state updates on the falling edge, matching PPU bus timing
- i_reset  input  1  synchronous, active-high reset
- i_video_rd_n  input  1  PPU read strobe, active low
- i_video_we_n  input  1  PPU write strobe, active low
- i_video_address  input  14  PPU video address
- i_video_data  input  8  write data from PPU
- o_video_data  output  8  read data to PPU
- i_mirror_vertical  input  1  1 = vertical mirroring, 0 = horizontal (mapper-driven)
- i_load_valid  input  1  loader request
- o_load_ready  output  1  loader may transfer this cycle
- i_load_address  input  14  loader address
- i_load_data  input  8  loader data
- o_write_count  output  WRITE_COUNT_WIDTH  committed video-bus writes, saturating
- o_last_write_address  output  14  address of the last video-bus write strobe
- o_bus_error  output  1  sticky: rd_n and we_n were low in the same cycle

Behaviour:
- Address decode, applied identically to video and loader accesses:
  - 0x0000-0x1FFF: CHR[a[12:0]].
  - 0x2000-0x3EFF: VRAM index. Vertical mirroring = {a[10], a[9:0]}; horizontal = {a[11], a[9:0]}. The same formula covers the 0x3000-0x3EFF mirror.
  - 0x3F00-0x3FFF (palette space, owned by the PPU): reads return VRAM at a-0x1000 with mirroring; writes are ignored.
- Read path:
  - o_video_data is combinational: the decoded byte while i_video_rd_n==0, else 0x00.
  - Zero-wait-state. The PPU holds rd_n low for one full cycle and captures on the falling edge that ends it.
- Write path:
  - On each falling edge with i_video_we_n==0, the byte is committed to the decoded location. The CHR region requires CHR_IS_RAM=1.
  - A write is visible to a read in the following cycle.
- Loader handshake:
  - o_load_ready = !i_reset && i_video_we_n (combinational). The video bus has priority.
  - Transfer occurs on a falling edge with i_load_valid && o_load_ready.
  - The loader writes CHR regardless of CHR_IS_RAM; palette-space loader writes are ignored.
  - The loader must hold address and data stable until it sees ready.
- Monitors:
  - o_write_count: increments on each committed video-bus write; palette and ROM-ignored writes do not count. Saturates at all-ones.
  - o_last_write_address: updated on every video write strobe, including ignored ones.
  - o_bus_error: set when rd_n==0 and we_n==0 in the same cycle. On that cycle the write is committed and read data is the pre-write value. Cleared only by reset.
- Reset:
  - o_write_count=0, o_last_write_address=0, o_bus_error=0, o_load_ready=0, o_video_data follows the read rule.
  - Memory arrays are not cleared.
  - Reset asserted mid-operation blocks any commit on that edge, for both video and loader writes.
- Mirroring change: takes effect on the next access; no stored state depends on it.

Decomposition:
- Shared package holds:
  - address region constants: CHR_BASE 0x0000, NT_BASE 0x2000, NT_MIRROR_END 0x3EFF, PALETTE_BASE 0x3F00;
  - sizes CHR_BYTES 8192, VRAM_BYTES 2048;
  - enum for region {REGION_CHR, REGION_NT, REGION_PALETTE}.
- One sub-module, ppu_video_address_decode, is combinational: address + mirror in, region + physical index out. It is shared by the video and loader paths.

Test Plan:
- Loader writes 0xA5 to 0x0010, CHR_IS_RAM=0 → PPU read of 0x0010 returns 0xA5. A video write of 0x11 to 0x0010 leaves it 0xA5 and o_write_count stays 0.
- Vertical mirroring: video write 0x42 to 0x2005 → read 0x2805 returns 0x42, and read 0x2405 does not. Horizontal mirroring: read 0x2405 returns 0x42.
- Read 0x3005 returns the 0x2005 byte. Write to 0x3F01: VRAM index 0x301 unchanged, o_write_count unchanged, o_last_write_address=0x3F01.
- Loader valid during a PPU write cycle → o_load_ready=0 for that cycle. The transfer completes on the next cycle and both bytes land correctly.
- rd_n and we_n low together → o_bus_error=1, held through 100 idle cycles; cleared by reset.
- 65540 committed writes with CHR_IS_RAM=1 → o_write_count=0xFFFF. Reset during a loader transfer → no byte committed, counters reset to 0.
